rx_fifo: RTL and testbench

Synchronous receive FIFO that buffers bytes written by the I2C slave datapath and serves them to the host-side register interface. It sits directly downstream of the slave core: it consumes the received byte and its write strobe, and it returns the full and almost-full status that the slave controller uses for clock stretching and NACK decisions. It has one clock domain, first-word-fall-through reads, and a synchronous flush.

---
 rtl/rx_fifo.sv | 129 ++++++++++++
 tb/tb_rx_fifo.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rx_fifo.sv
// rx_fifo: single-clock receive FIFO between the I2C slave core and the host
// register interface. Reads are first-word-fall-through: read_data always shows
// the head entry. Status flags decode from a registered occupancy counter, so
// they have no combinational path from any input.
// Optional feature macro: RX_FIFO_OVERRUN_DETECT_EN adds a sticky `overrun`
// output that records writes dropped because the FIFO was full.
module rx_fifo #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AF_LEVEL = DEPTH - 1
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     write_enable,
  input  logic [7:0]               write_data,
  input  logic                     read_enable,
  input  logic                     clear,
  output logic [7:0]               read_data,
  output logic                     fifo_empty,
  output logic                     fifo_full,
  output logic                     fifo_almost_full,
  output logic [$clog2(DEPTH):0]   count
`ifdef RX_FIFO_OVERRUN_DETECT_EN
  ,
  output logic                     overrun
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          full_w;
  logic          empty_w;
  logic          wr_acc;
  logic          rd_acc;

  // Status decode from the registered count only.
  always_comb begin
    empty_w = (count_q == '0);
    full_w  = (count_q == CW'(DEPTH));
  end

  assign fifo_empty       = empty_w;
  assign fifo_full        = full_w;
  assign fifo_almost_full = (count_q >= CW'(AF_LEVEL));
  assign count            = count_q;
  assign read_data        = mem_q[rd_ptr_q];

  // Accept logic. A write while full is still accepted when a pop frees the
  // head slot in the same cycle; a read needs a non-empty FIFO, so an
  // empty-FIFO read+write resolves to the write only.
  always_comb begin
    rd_acc = read_enable && !empty_w;
    wr_acc = write_enable && (!full_w || rd_acc);
  end

  // Next-state for storage, pointers and occupancy; clear overrides traffic.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) begin
        mem_d[wr_ptr_q] = write_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; reset also zeroes memory so read_data is defined.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

`ifdef RX_FIFO_OVERRUN_DETECT_EN
  logic overrun_q, overrun_d;

  // Sticky overrun: set by a write that finds the FIFO full with no pop to
  // make room; only clear or reset drop it, and clear wins a same-cycle set.
  always_comb begin
    overrun_d = overrun_q;
    if (clear) begin
      overrun_d = 1'b0;
    end else if (write_enable && full_w && !rd_acc) begin
      overrun_d = 1'b1;
    end
  end

  // Overrun flag register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_rx_fifo.sv
// Directed testbench for rx_fifo (DEPTH=8, AF_LEVEL=7).
module tb_rx_fifo;

  logic       clk;
  logic       n_rst;
  logic       write_enable;
  logic [7:0] write_data;
  logic       read_enable;
  logic       clear;
  logic [7:0] read_data;
  logic       fifo_empty;
  logic       fifo_full;
  logic       fifo_almost_full;
  logic [3:0] count;
`ifdef RX_FIFO_OVERRUN_DETECT_EN
  logic       overrun;
`endif

  int tests;
  int fails;

  rx_fifo #(.DEPTH(8), .AF_LEVEL(7)) dut (
    .clk              (clk),
    .n_rst            (n_rst),
    .write_enable     (write_enable),
    .write_data       (write_data),
    .read_enable      (read_enable),
    .clear            (clear),
    .read_data        (read_data),
    .fifo_empty       (fifo_empty),
    .fifo_full        (fifo_full),
    .fifo_almost_full (fifo_almost_full),
    .count            (count)
`ifdef RX_FIFO_OVERRUN_DETECT_EN
    ,
    .overrun          (overrun)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle; inputs change here, outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write_enable = 1'b0;
    read_enable  = 1'b0;
    clear        = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    write_data = 8'h00;
    n_rst = 1'b0;
    #12;
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
    tests++; if (fifo_empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b want 1", fifo_empty); end
    tests++; if (fifo_full !== 1'b0) begin fails++; $display("FAIL reset_full got %b want 0", fifo_full); end
    tests++; if (fifo_almost_full !== 1'b0) begin fails++; $display("FAIL reset_af got %b want 0", fifo_almost_full); end
    tests++; if (read_data !== 8'h00) begin fails++; $display("FAIL reset_rdata got %h want 00", read_data); end
`ifdef RX_FIFO_OVERRUN_DETECT_EN
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun got %b want 0", overrun); end
`endif
    @(negedge clk);
    n_rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    write_enable = 1'b1; write_data = 8'hA5;
    tick();
    idle();
    tests++; if (read_data !== 8'hA5) begin fails++; $display("FAIL single_rdata got %h want a5", read_data); end
    tests++; if (count !== 4'd1) begin fails++; $display("FAIL single_count got %0d want 1", count); end
    tests++; if (fifo_empty !== 1'b0) begin fails++; $display("FAIL single_empty got %b want 0", fifo_empty); end
    read_enable = 1'b1;
    tick();
    idle();
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL single_pop_count got %0d want 0", count); end
    tests++; if (fifo_empty !== 1'b1) begin fails++; $display("FAIL single_pop_empty got %b want 1", fifo_empty); end
    // a pop on an empty FIFO must be ignored
    read_enable = 1'b1;
    tick();
    idle();
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL empty_pop_count got %0d want 0", count); end
  endtask

  task automatic test_fill_drop();
    for (int i = 0; i < 8; i++) begin
      write_enable = 1'b1; write_data = 8'(i);
      tick();
      tests++; if (count !== 4'(i + 1)) begin fails++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i + 1); end
      tests++; if (fifo_almost_full !== ((i + 1) >= 7)) begin fails++; $display("FAIL fill_af[%0d] got %b", i, fifo_almost_full); end
      tests++; if (fifo_full !== ((i + 1) == 8)) begin fails++; $display("FAIL fill_full[%0d] got %b", i, fifo_full); end
    end
    write_data = 8'hFF;
    tick();
    idle();
    tests++; if (count !== 4'd8) begin fails++; $display("FAIL drop_count got %0d want 8", count); end
    tests++; if (read_data !== 8'h00) begin fails++; $display("FAIL drop_head got %h want 00", read_data); end
`ifdef RX_FIFO_OVERRUN_DETECT_EN
    tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL drop_overrun got %b want 1", overrun); end
`endif
    for (int i = 0; i < 8; i++) begin
      tests++; if (read_data !== 8'(i)) begin fails++; $display("FAIL drain_data[%0d] got %h want %h", i, read_data, 8'(i)); end
      read_enable = 1'b1;
      tick();
    end
    idle();
    tests++; if (fifo_empty !== 1'b1) begin fails++; $display("FAIL drain_empty got %b want 1", fifo_empty); end
`ifdef RX_FIFO_OVERRUN_DETECT_EN
    tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL overrun_sticky got %b want 1", overrun); end
`endif
  endtask

  task automatic test_wrap();
    logic [7:0] exp;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) begin
        write_enable = 1'b1; write_data = 8'((r * 8'h37 + i * 8'h11) ^ 8'hC3);
        tick();
        tests++; if (count > 4'd8) begin fails++; $display("FAIL wrap_count r%0d i%0d got %0d max 8", r, i, count); end
      end
      idle();
      for (int i = 0; i < 8; i++) begin
        exp = 8'((r * 8'h37 + i * 8'h11) ^ 8'hC3);
        tests++; if (read_data !== exp) begin fails++; $display("FAIL wrap_data r%0d i%0d got %h want %h", r, i, read_data, exp); end
        read_enable = 1'b1;
        tick();
      end
      idle();
      tests++; if (count !== 4'd0) begin fails++; $display("FAIL wrap_end_count r%0d got %0d want 0", r, count); end
    end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 8; i++) begin
      write_enable = 1'b1; write_data = 8'(8'h80 + i);
      tick();
    end
    write_enable = 1'b1; read_enable = 1'b1; write_data = 8'h5A;
    tick();
    idle();
    tests++; if (count !== 4'd8) begin fails++; $display("FAIL full_rw_count got %0d want 8", count); end
    tests++; if (read_data !== 8'h81) begin fails++; $display("FAIL full_rw_head got %h want 81", read_data); end
    for (int i = 1; i < 9; i++) begin
      tests++; if (read_data !== ((i == 8) ? 8'h5A : 8'(8'h80 + i))) begin fails++; $display("FAIL full_rw_drain[%0d] got %h", i, read_data); end
      read_enable = 1'b1;
      tick();
    end
    idle();
    tests++; if (fifo_empty !== 1'b1) begin fails++; $display("FAIL full_rw_empty got %b want 1", fifo_empty); end
  endtask

  task automatic test_empty_rw();
    write_enable = 1'b1; read_enable = 1'b1; write_data = 8'h3C;
    tick();
    idle();
    tests++; if (count !== 4'd1) begin fails++; $display("FAIL empty_rw_count got %0d want 1", count); end
    tests++; if (read_data !== 8'h3C) begin fails++; $display("FAIL empty_rw_data got %h want 3c", read_data); end
    read_enable = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_clear();
    for (int i = 0; i < 3; i++) begin
      write_enable = 1'b1; write_data = 8'(8'h20 + i);
      tick();
    end
    clear = 1'b1; write_enable = 1'b1; write_data = 8'h77;
    tick();
    idle();
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL clear_count got %0d want 0", count); end
    tests++; if (fifo_empty !== 1'b1) begin fails++; $display("FAIL clear_empty got %b want 1", fifo_empty); end
`ifdef RX_FIFO_OVERRUN_DETECT_EN
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL clear_overrun got %b want 0", overrun); end
    for (int i = 0; i < 8; i++) begin
      write_enable = 1'b1; write_data = 8'(i);
      tick();
    end
    clear = 1'b1;
    tick();
    idle();
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL clear_vs_overrun got %b want 0", overrun); end
`endif
    write_enable = 1'b1; write_data = 8'h99;
    tick();
    idle();
    tests++; if (read_data !== 8'h99) begin fails++; $display("FAIL post_clear_data got %h want 99", read_data); end
    read_enable = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      write_enable = 1'b1; write_data = 8'(8'hD0 + i);
      tick();
    end
    idle();
    #2;
    n_rst = 1'b0;
    #1;
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL areset_count got %0d want 0", count); end
    tests++; if (fifo_empty !== 1'b1) begin fails++; $display("FAIL areset_empty got %b want 1", fifo_empty); end
    tests++; if (read_data !== 8'h00) begin fails++; $display("FAIL areset_rdata got %h want 00", read_data); end
    tests++; if (fifo_almost_full !== 1'b0) begin fails++; $display("FAIL areset_af got %b want 0", fifo_almost_full); end
    @(negedge clk);
    n_rst = 1'b1;
    tick();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_single();
    test_fill_drop();
    test_wrap();
    test_full_rw();
    test_empty_rw();
    test_clear();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
